// File: rtl/seq_multiplier16.sv
// Unsigned 16x16->32 shift-and-add multiplier that time-shares the external
// 16-bit ripple adder, one partial-product step per clock over 16 cycles.
module seq_multiplier16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mlr_q, mlr_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   step_shift;

  // Carry-out lands in acc[15], so the 33-bit sum/shift never loses a bit.
  assign step_shift = {add_cout, add_sum, mlr_q[WIDTH-1:1]};

  assign product = product_q;
  assign add_cin = 1'b0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    mlr_d     = mlr_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          mlr_d   = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        add_a = acc_q;
        add_b = mlr_q[0] ? mcand_q : '0;
        {acc_d, mlr_d} = step_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          product_d = step_shift;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Start is deliberately not looked at here; a request must be re-issued in IDLE.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values computed before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the product, is reset so a mid-run
      // abort leaves no stale result or partial product behind.
      state_q   <= IDLE;
      acc_q     <= '0;
      mlr_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mlr_q     <= mlr_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier16.sv
// Directed bench for seq_multiplier16; the 16-bit ripple adder is modelled here.
module tb_seq_multiplier16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  seq_multiplier16 #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, " busy"},    32'(busy), 32'd0);
    check({tag, " done"},    32'(done), 32'd0);
    check({tag, " add_a"},   32'(add_a), 32'd0);
    check({tag, " add_b"},   32'(add_b), 32'd0);
    check({tag, " add_cin"}, 32'(add_cin), 32'd0);
  endtask

  // One full multiply; inject=1 fires extra starts at edge T5 and during DONE.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input bit inject, input string tag);
    int busy_n = 0;
    int bad_b = 0;
    int early_done = 0;
    int prod_moved = 0;
    int d0 = done_cnt;
    logic [31:0] prev_p = product;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = '0; multiplier = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done !== 1'b0) early_done++;
      if (add_b !== (b[k] ? a : 16'h0000)) bad_b++;
      if (product !== prev_p) prod_moved++;
      if (inject && k == 4) begin
        start = 1'b1; multiplicand = 16'h1111; multiplier = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0; multiplicand = '0; multiplier = '0;
      end
    end
    @(negedge clk);
    check({tag, " busy cycles"},    32'(busy_n), 32'd16);
    check({tag, " add_b steps"},    32'(bad_b), 32'd0);
    check({tag, " early done"},     32'(early_done), 32'd0);
    check({tag, " product hold"},   32'(prod_moved), 32'd0);
    check({tag, " done at T16"},    32'(done), 32'd1);
    check({tag, " busy in DONE"},   32'(busy), 32'd0);
    check({tag, " product"},        product, exp_p);
    if (inject) begin
      start = 1'b1; multiplicand = 16'h1111; multiplier = 16'h2222;
      @(posedge clk); #1;
      start = 1'b0; multiplicand = '0; multiplier = '0;
    end
    @(negedge clk);
    check({tag, " done cleared"},   32'(done), 32'd0);
    check({tag, " idle after"},     32'(busy), 32'd0);
    check({tag, " done pulses"},    32'(done_cnt - d0), 32'd1);
    if (inject) begin
      @(negedge clk);
      check({tag, " no new run"},   32'(busy), 32'd0);
      check({tag, " product kept"}, product, exp_p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int d0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release with no start: outputs stay quiet for 20 cycles.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 ||
          add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) bad++;
    end
    check("reset quiet cycles", 32'(bad), 32'd0);
    idle_outputs("reset");
    check("reset product", product, 32'h0000_0000);

    run_mul(16'h0003, 16'h0005, 32'h0000_000F, 1'b0, "3x5");
    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, "max");
    run_mul(16'h0000, 16'h1234, 32'h0000_0000, 1'b0, "zero");
    run_mul(16'h8000, 16'h0002, 32'h0001_0000, 1'b0, "8000x2");
    run_mul(16'h0007, 16'h0009, 32'h0000_003F, 1'b1, "7x9 ignored");
    run_mul(16'h0003, 16'h0004, 32'h0000_000C, 1'b0, "accept after");
    idle_outputs("between ops");

    // Reset in the middle of a run.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h00FF; multiplier = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (7) @(posedge clk);
    @(posedge clk); #2;
    check("mid-run busy before rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    idle_outputs("mid-run rst");
    check("mid-run rst product", product, 32'h0000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("aborted op no done", 32'(done_cnt - d0), 32'd0);
    check("aborted op product", product, 32'h0000_0000);

    run_mul(16'h0002, 16'h0002, 32'h0000_0004, 1'b0, "2x2 after rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
